mfcc_frame_sequencer: RTL and testbench
=======================================

Name: mfcc_frame_sequencer

Overview:
- Controller between the pre-emphasis stage and the FFT in the MFCC pipeline.
- Buffers the pre-emphasised PCM stream in a circular sample buffer and emits overlapping frames of FRAME_SIZE samples, advancing FRAME_MOVE samples per frame.
- Zero-pads each frame to FFT_SIZE and streams it to the FFT over a valid/ready handshake.
- Tracks frame count and provides flush control.

Parameters:
- SAMPLE_WIDTH, 16, PCM sample width in bits.
- FRAME_SIZE, 400, samples per analysis frame.
- FRAME_MOVE, 160, hop between consecutive frame starts.
- FFT_SIZE, 512, beats per emitted frame; beats beyond FRAME_SIZE are zero padding.
- BUF_DEPTH, 512, circular buffer depth. Must be a power of 2 and >= FRAME_SIZE. Legal configuration: 1 <= FRAME_MOVE <= FRAME_SIZE <= FFT_SIZE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  one-cycle pulse: discard buffered samples, abort the current frame.
- in_data_i  in  SAMPLE_WIDTH  pre-emphasised sample.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  sequencer can accept a sample.
- out_data_o  out  SAMPLE_WIDTH  frame sample or zero pad.
- out_index_o  out  $clog2(FFT_SIZE)  beat index within the frame, 0..FFT_SIZE-1.
- out_valid_o  out  1  output beat valid.
- out_last_o  out  1  high on the beat with index FFT_SIZE-1.
- out_ready_i  in  1  FFT accepts the beat.
- frame_count_o  out  16  number of completed frames; wraps at 65535->0.
- busy_o  out  1  high when state != IDLE.

Behaviour:
- Reset: all outputs 0, except in_ready_o=1 from the first cycle after rst deasserts. Pointers, occupancy and frame_count are cleared; state=IDLE. Reset is synchronous and may be asserted at any cycle, mid-frame included. It aborts the frame with no out_last_o. Buffer RAM contents need not be cleared.
- Pointers:
  - wr_ptr and base_ptr are modulo BUF_DEPTH.
  - occupancy = samples written minus base_ptr advance; range 0..BUF_DEPTH.
- Input:
  - in_ready_o = (occupancy < BUF_DEPTH).
  - A transfer occurs when in_valid_i && in_ready_o. It writes buf[wr_ptr], then wr_ptr++ and occupancy++.
  - This rule guarantees writes never overwrite [base_ptr, base_ptr+FRAME_SIZE) while a frame is being read.
- State machine:
  - IDLE: when occupancy >= FRAME_SIZE, go to STREAM with rd_idx=0.
  - STREAM: each accepted beat carries buf[base_ptr+rd_idx] and index rd_idx. After beat FRAME_SIZE-1 is accepted, go to PAD, or to ADVANCE if FRAME_SIZE == FFT_SIZE.
  - PAD: emit data 0 for indices FRAME_SIZE..FFT_SIZE-1. Beat FFT_SIZE-1 carries out_last_o=1. On acceptance, go to ADVANCE.
  - ADVANCE (one cycle): base_ptr += FRAME_MOVE, occupancy -= FRAME_MOVE, frame_count_o++, then go to IDLE.
  - If a write and the occupancy decrement land in the same cycle, the net change is +1-FRAME_MOVE.
- Output handshake:
  - The output register loads a new beat when !out_valid_o || out_ready_i.
  - data, index and last are stable while out_valid_o && !out_ready_i.
  - out_valid_o never drops without acceptance, except on rst or flush.
  - Back-to-back beats are allowed (1 beat/cycle when out_ready_i is held high).
  - Latency: first beat valid at most 2 cycles after occupancy reaches FRAME_SIZE in IDLE.
- Flush:
  - Clears occupancy, wr_ptr, base_ptr, out_valid_o and out_last_o; state=IDLE.
  - frame_count_o is preserved.
  - A sample presented in the flush cycle is dropped, with in_ready_o forced 0 that cycle.
  - A flush in ADVANCE still leaves frame_count unincremented.
- Only one frame is in flight at a time. Frame k starts at input sample k*FRAME_MOVE.

Optional Feature:
- Macro: MFCC_FRAME_SEQ_OVERRUN_EN.
- When defined, adds two outputs:
  - overrun_o (1 bit, sticky): sets when in_valid_i && !in_ready_o; clears on rst or flush_i.
  - overrun_count_o (16 bit, saturating): counts such cycles.
- Upstream sources without backpressure (PCM FIFO strobes) can then report lost samples.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Ramp input 0..399, out_ready=1 → one frame:
  - beats 0..399 carry 0..399, beats 400..511 carry 0;
  - out_last only at index 511; frame_count=1.
- Continuous ramp 0..1599, out_ready=1 → frames start at samples 0, 160, 320, 480, 640, ...:
  - frame 1 beat 0 = 160 and beat 399 = 559;
  - no sample is skipped or duplicated.
- out_ready_i low for 10 cycles at beat 200 → data/index held at 200; resumes with 201; no loss.
- out_ready_i=0 for the whole run, input always valid → 512 samples accepted, then in_ready_o=0. With the macro, overrun_o=1 and overrun_count increments each stalled cycle.
- flush_i at beat 250 of frame 2 → out_valid_o=0 next cycle; frame_count stays 2; the next frame starts only after 400 new samples, with beat 0 = the first post-flush sample.
- rst asserted at beat 100, held 1 cycle → all outputs 0 and in_ready_o=1 next cycle; 400 new samples give a frame starting at the first new sample.

Source files
------------

// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer
// Sits between pre-emphasis and the FFT. Incoming PCM samples are kept in a
// circular buffer; once a full frame is buffered, FRAME_SIZE samples are
// streamed from base_ptr, then zero padding up to FFT_SIZE beats. After the
// final beat is accepted the frame start hops by FRAME_MOVE samples.
//
// Optional build macro: MFCC_FRAME_SEQ_OVERRUN_EN
//   Adds overrun_o (sticky) and overrun_count_o (saturating). These flag cycles
//   where upstream presented a sample that could not be taken.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for occupancy >= FRAME_SIZE
// STREAM   | issuing buffered samples, beat indices 0..FRAME_SIZE-1
// PAD      | issuing zero beats, indices FRAME_SIZE..FFT_SIZE-1
// ADVANCE  | one cycle: hop base_ptr, release FRAME_MOVE slots, count frame
module mfcc_frame_sequencer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_SIZE   = 400,
    parameter int FRAME_MOVE   = 160,
    parameter int FFT_SIZE     = 512,
    parameter int BUF_DEPTH    = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic [SAMPLE_WIDTH-1:0]     in_data_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [SAMPLE_WIDTH-1:0]     out_data_o,
    output logic [$clog2(FFT_SIZE)-1:0] out_index_o,
    output logic                        out_valid_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic [15:0]                 frame_count_o,
    output logic                        busy_o
`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
    ,
    output logic                        overrun_o,
    output logic [15:0]                 overrun_count_o
`endif
);

    localparam int IDXW = $clog2(FFT_SIZE);
    localparam int PTRW = $clog2(BUF_DEPTH);

    localparam logic [IDXW:0]   LAST_DATA_IDX = (IDXW+1)'(FRAME_SIZE - 1);
    localparam logic [IDXW:0]   LAST_BEAT_IDX = (IDXW+1)'(FFT_SIZE - 1);
    localparam logic [IDXW:0]   BEAT_END      = (IDXW+1)'(FFT_SIZE);
    localparam logic [PTRW:0]   OCC_FULL      = (PTRW+1)'(BUF_DEPTH);
    localparam logic [PTRW:0]   OCC_FRAME     = (PTRW+1)'(FRAME_SIZE);
    localparam logic [PTRW:0]   OCC_MOVE      = (PTRW+1)'(FRAME_MOVE);
    localparam logic [PTRW-1:0] PTR_MOVE      = PTRW'(FRAME_MOVE);
    localparam bit              HAS_PAD       = (FRAME_SIZE < FFT_SIZE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STREAM  = 2'd1;
    localparam logic [1:0] S_PAD     = 2'd2;
    localparam logic [1:0] S_ADVANCE = 2'd3;

    logic [1:0]              state;
    logic [SAMPLE_WIDTH-1:0] sample_buf [BUF_DEPTH];
    logic [PTRW-1:0]         wr_ptr;
    logic [PTRW-1:0]         base_ptr;
    logic [PTRW-1:0]         rd_addr;
    logic [PTRW:0]           occupancy;
    logic [IDXW:0]           rd_idx;
    logic                    in_accept;
    logic                    beat_issue;
    logic                    last_accept;

    // Input side: ready is withheld during reset and flush so such a sample is dropped
    always_comb begin
        in_ready_o  = !rst && !flush_i && (occupancy < OCC_FULL);
        in_accept   = in_valid_i && in_ready_o;
        rd_addr     = base_ptr + PTRW'(rd_idx);
        beat_issue  = ((state == S_STREAM) || (state == S_PAD)) &&
                      (!out_valid_o || out_ready_i) && (rd_idx != BEAT_END);
        last_accept = out_valid_o && out_ready_i && out_last_o;
        busy_o      = (state != S_IDLE);
    end

    // Sample storage; never reset, occupancy decides what is meaningful
    always_ff @(posedge clk) begin
        if (in_accept) begin
            sample_buf[wr_ptr] <= in_data_i;
        end
    end

    // Write pointer and occupancy; a write and a frame hop may coincide
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (in_accept) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            occupancy <= occupancy + {{PTRW{1'b0}}, in_accept}
                         - ((state == S_ADVANCE) ? OCC_MOVE : '0);
        end
    end

    // Frame FSM and output beat register
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rd_idx        <= '0;
            base_ptr      <= '0;
            frame_count_o <= '0;
            out_valid_o   <= 1'b0;
            out_last_o    <= 1'b0;
            out_data_o    <= '0;
            out_index_o   <= '0;
        end else if (flush_i) begin
            state       <= S_IDLE;
            rd_idx      <= '0;
            base_ptr    <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            out_index_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (occupancy >= OCC_FRAME) begin
                        rd_idx <= '0;
                        state  <= S_STREAM;
                    end
                end
                S_STREAM, S_PAD: begin
                    if (beat_issue) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= (state == S_STREAM) ? sample_buf[rd_addr] : '0;
                        out_index_o <= rd_idx[IDXW-1:0];
                        out_last_o  <= (rd_idx == LAST_BEAT_IDX);
                        rd_idx      <= rd_idx + (IDXW+1)'(1);
                        if (HAS_PAD && (state == S_STREAM) && (rd_idx == LAST_DATA_IDX)) begin
                            state <= S_PAD;
                        end
                    end else if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                    end
                    if (last_accept) begin
                        state <= S_ADVANCE;
                    end
                end
                default: begin
                    base_ptr      <= base_ptr + PTR_MOVE;
                    frame_count_o <= frame_count_o + 16'd1;
                    rd_idx        <= '0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
    // Lost-sample reporting for sources that ignore backpressure
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            overrun_o       <= 1'b0;
            overrun_count_o <= '0;
        end else if (in_valid_i && !in_ready_o) begin
            overrun_o <= 1'b1;
            if (overrun_count_o != 16'hFFFF) begin
                overrun_count_o <= overrun_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Bench for mfcc_frame_sequencer. Reference model: every accepted sample since
// the last reset/flush goes into a queue; beat i of frame k must carry
// sample[k*FRAME_MOVE + i] for i < FRAME_SIZE, else zero, last only at FFT_SIZE-1.
module tb_mfcc_frame_sequencer;
    localparam int SW  = 16;
    localparam int FS  = 400;
    localparam int FM  = 160;
    localparam int FFT = 512;
    localparam int BD  = 512;
    localparam int IW  = $clog2(FFT);

    logic          clk;
    logic          rst;
    logic          flush;
    logic [SW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [15:0]   frame_count;
    logic          busy;
`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
    logic          overrun;
    logic [15:0]   overrun_count;
`endif

    mfcc_frame_sequencer #(
        .SAMPLE_WIDTH(SW), .FRAME_SIZE(FS), .FRAME_MOVE(FM),
        .FFT_SIZE(FFT), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_index_o(out_index), .out_valid_o(out_valid),
        .out_last_o(out_last), .out_ready_i(out_ready),
        .frame_count_o(frame_count), .busy_o(busy)
`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
        , .overrun_o(overrun), .overrun_count_o(overrun_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   frame;
        int   idx;
        int   data;
        logic last;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          samp[$];
    int          mk = 0;
    int          midx = 0;
    logic [15:0] mfc = 0;
    bit          cap_en = 0;
    bit          in_acc = 0;
    int          first_beat = -1;
    int          cap_data [8][FFT];
    logic        cap_last [8][FFT];
    vec_t        vecs[$];

    bit          pv, pr, pl, pc;
    logic [SW-1:0] pd;
    logic [IW-1:0] pi;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_beat();
        int   pos;
        int   exp_d;
        logic exp_l;
        pos   = mk * FM + midx;
        exp_l = (midx == FFT - 1);
        if (midx < FS) exp_d = (pos < samp.size()) ? samp[pos] : -1;
        else           exp_d = 0;
        checks++;
        if (int'(out_index) != midx || int'(out_data) != exp_d || out_last != exp_l) begin
            failures++;
            $display("FAIL beat frame=%0d: got idx=%0d data=%0d last=%0d expected idx=%0d data=%0d last=%0d",
                     mk, out_index, out_data, out_last, midx, exp_d, exp_l);
        end
        if (first_beat < 0) first_beat = int'(out_data);
        if (cap_en && mk < 8) begin
            cap_data[mk][int'(out_index)] = int'(out_data);
            cap_last[mk][int'(out_index)] = out_last;
        end
        midx++;
        if (midx == FFT) begin
            midx = 0;
            mk++;
            mfc++;
        end
    endtask

    // One clock: observe handshakes on settled inputs, advance, check hold rule
    task automatic step();
        #1;
        in_acc = 0;
        if (rst) begin
            samp.delete(); mk = 0; midx = 0; mfc = 0;
        end else if (flush) begin
            samp.delete(); mk = 0; midx = 0;
        end else begin
            if (in_valid && in_ready) begin
                samp.push_back(int'(in_data));
                in_acc = 1;
            end
            if (out_valid && out_ready) check_beat();
        end
        pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
        pc = rst || flush;
        @(posedge clk);
        #1;
        cyc++;
        if (pv && !pr && !pc) begin
            checks++;
            if (!out_valid || out_data != pd || out_index != pi || out_last != pl) begin
                failures++;
                $display("FAIL hold: got v=%0d d=%0d i=%0d l=%0d expected v=1 d=%0d i=%0d l=%0d",
                         out_valid, out_data, out_index, out_last, pd, pi, pl);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_index"}, out_index, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_overrun_count"}, overrun_count, 0);
`endif
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        step();
        step();
        rst = 0;
        #1;
        check_idle("reset");
    endtask

    task automatic settle(input int n);
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int nv, stall_cnt, lat_start, acc_cnt, stall_cyc;
        bit stalled, lat_done, fc1_done, hit;

        for (int f = 0; f < 8; f++)
            for (int i = 0; i < FFT; i++) begin
                cap_data[f][i] = -1;
                cap_last[f][i] = 1'b0;
            end
        vecs.push_back('{0, 0, 0, 1'b0});
        vecs.push_back('{0, 200, 200, 1'b0});
        vecs.push_back('{0, 201, 201, 1'b0});
        vecs.push_back('{0, 399, 399, 1'b0});
        vecs.push_back('{0, 400, 0, 1'b0});
        vecs.push_back('{0, 510, 0, 1'b0});
        vecs.push_back('{0, 511, 0, 1'b1});
        vecs.push_back('{1, 0, 160, 1'b0});
        vecs.push_back('{1, 399, 559, 1'b0});
        vecs.push_back('{1, 511, 0, 1'b1});
        vecs.push_back('{2, 0, 320, 1'b0});
        vecs.push_back('{3, 0, 480, 1'b0});
        vecs.push_back('{4, 0, 640, 1'b0});
        vecs.push_back('{7, 0, 1120, 1'b0});
        vecs.push_back('{7, 399, 1519, 1'b0});
        vecs.push_back('{7, 511, 0, 1'b1});

        // Continuous ramp 0..1599 with a 10-cycle stall at frame 0 beat 200
        do_reset();
        cap_en = 1; nv = 0; stall_cnt = 0; stalled = 0;
        lat_start = -1; lat_done = 0; fc1_done = 0;
        for (int c = 0; c < 8000 && !(mk == 8 && nv == 1600); c++) begin
            in_valid = (nv < 1600);
            in_data  = 16'(nv);
            if (!stalled && out_valid && out_index == 200 && mk == 0) begin
                stalled = 1;
                stall_cnt = 10;
            end
            out_ready = (stall_cnt == 0);
            step();
            if (in_acc) begin
                nv++;
                if (nv == FS) lat_start = cyc;
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) begin
                    chk("stall_hold_index", out_index, 200);
                    chk("stall_hold_data", out_data, 200);
                end
            end
            if (lat_start >= 0 && !lat_done && out_valid) begin
                lat_done = 1;
                chk("first_beat_latency_le2", int'((cyc - lat_start) <= 2), 1);
            end
            if (!fc1_done && mk == 1 && out_valid) begin
                fc1_done = 1;
                chk("frame_count_after_frame0", frame_count, 1);
            end
        end
        chk("ramp_complete", int'(mk == 8 && nv == 1600), 1);
        chk("stall_seen", stalled, 1);
        chk("latency_seen", lat_done, 1);
        settle(6);
        chk("ramp_frame_count", frame_count, 8);
        chk("ramp_busy_idle", busy, 0);
        cap_en = 0;
        foreach (vecs[v]) begin
            chk($sformatf("vec_f%0d_i%0d_data", vecs[v].frame, vecs[v].idx),
                cap_data[vecs[v].frame][vecs[v].idx], vecs[v].data);
            chk($sformatf("vec_f%0d_i%0d_last", vecs[v].frame, vecs[v].idx),
                cap_last[vecs[v].frame][vecs[v].idx], vecs[v].last);
        end

        // Output never accepted: buffer fills to BUF_DEPTH then backpressures
        do_reset();
        acc_cnt = 0; stall_cyc = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid = 1; in_data = 16'(1000 + c); out_ready = 0;
            step();
            if (in_acc) acc_cnt++;
            else stall_cyc++;
        end
        chk("full_accepted", acc_cnt, BD);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_index", out_index, 0);
        chk("full_out_data", out_data, 1000);
`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
        chk("overrun_set", overrun, 1);
        chk("overrun_count", overrun_count, stall_cyc);
`endif
        flush = 1; in_valid = 0;
        step();
        flush = 0;
        chk("full_flush_valid", out_valid, 0);
`ifdef MFCC_FRAME_SEQ_OVERRUN_EN
        chk("overrun_cleared", overrun, 0);
`endif

        // Flush at beat 250 of frame 2
        do_reset();
        nv = 0; hit = 0;
        for (int c = 0; c < 6000 && !hit; c++) begin
            if (out_valid && mk == 2 && out_index == 250) begin
                hit = 1;
            end else begin
                in_valid = 1; in_data = 16'(nv); out_ready = 1;
                step();
                if (in_acc) nv++;
            end
        end
        chk("flush_point_reached", hit, 1);
        flush = 1; in_valid = 1; in_data = 16'hBEEF; out_ready = 0;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_last", out_last, 0);
        chk("flush_frame_count", frame_count, 2);
        first_beat = -1; nv = 5000;
        for (int c = 0; c < 3000 && mk < 1; c++) begin
            in_valid = 1; in_data = 16'(nv); out_ready = 1;
            step();
            if (in_acc) nv++;
        end
        chk("post_flush_first_beat", first_beat, 5000);
        settle(6);
        chk("post_flush_frame_count", frame_count, 3);

        // Reset at beat 100 of a frame
        nv = 7000; hit = 0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            if (out_valid && out_index == 100) begin
                hit = 1;
            end else begin
                in_valid = 1; in_data = 16'(nv); out_ready = 1;
                step();
                if (in_acc) nv++;
            end
        end
        chk("rst_point_reached", hit, 1);
        rst = 1; in_valid = 1; out_ready = 1;
        step();
        rst = 0; in_valid = 0;
        #1;
        check_idle("rst_mid");
        first_beat = -1; nv = 9000;
        for (int c = 0; c < 3000 && mk < 1; c++) begin
            in_valid = 1; in_data = 16'(nv); out_ready = 1;
            step();
            if (in_acc) nv++;
        end
        chk("post_rst_first_beat", first_beat, 9000);
        settle(6);
        chk("post_rst_frame_count", frame_count, 1);

        // Randomized traffic against the queue model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        settle(2500);
        chk("rand_frame_count", frame_count, int'(mfc));
        chk("rand_busy_idle", busy, 0);
        chk("rand_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
